// File: rtl/gtxe2_chnl_pkg.sv
// Shared definitions for the GTXE2 channel TX blocks.
// Holds the TX buffer controller state encoding and the bit positions
// inside the two-bit TXBUFSTATUS word.
package gtxe2_chnl_pkg;

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_FLUSH = 3'd1,
        ST_FILL  = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERR   = 3'd4
    } bufctrl_state_t;

    // TXBUFSTATUS[0]: buffer at least half full
    localparam int unsigned TXBUFSTATUS_HALF = 0;
    // TXBUFSTATUS[1]: sticky underflow/overflow
    localparam int unsigned TXBUFSTATUS_ERR  = 1;

endpackage

// File: rtl/gtxe2_chnl_tx_bufctrl.sv
// TX buffer controller (usrclk domain).
// Sequences flush and initial fill of the usrclk2->usrclk resync FIFO,
// issues the per-interface-word read strobe aligned to the width-conversion
// phase, detects under/overflow and reports TXBUFSTATUS / TXRESETDONE.
//
// Ports:
//   usrclk         internal TX clock
//   reset          synchronous active-high reset
//   txuserrdy      user ready; low forces the RST state
//   txbufreset_req single-cycle flush request
//   fifo_empty     buffer empty (read side)
//   fifo_full      buffer full (resynced to usrclk)
//   fifo_level     buffer occupancy (read side)
//   fifo_rst       reset to both sides of the buffer
//   rd_en          buffer read strobe
//   word_phase     internal sub-word index 0..div-1
//   txbufstatus    [1] sticky under/overflow, [0] occupancy >= half depth
//   txresetdone    buffer running, data valid
module gtxe2_chnl_tx_bufctrl
    import gtxe2_chnl_pkg::*;
#(
    parameter int unsigned div          = 2,
    parameter int unsigned log_depth    = 3,
    parameter int unsigned flush_cycles = 8,
    parameter int unsigned fill_level   = 4,
    parameter int unsigned fill_timeout = 64,
    parameter int unsigned auto_recover = 1
) (
    input  logic                 usrclk,
    input  logic                 reset,
    input  logic                 txuserrdy,
    input  logic                 txbufreset_req,
    input  logic                 fifo_empty,
    input  logic                 fifo_full,
    input  logic [log_depth:0]   fifo_level,
    output logic                 fifo_rst,
    output logic                 rd_en,
    output logic [1:0]           word_phase,
    output logic [1:0]           txbufstatus,
    output logic                 txresetdone
);

    localparam int unsigned LVL_W   = log_depth + 1;
    localparam int unsigned CNT_MAX = (flush_cycles > fill_timeout) ? flush_cycles : fill_timeout;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] FLUSH_LAST   = CNT_W'(flush_cycles - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(fill_timeout - 1);
    localparam logic [1:0]       PHASE_LAST   = 2'(div - 1);
    localparam logic [LVL_W-1:0] FILL_THR     = LVL_W'(fill_level);
    localparam logic [LVL_W-1:0] HALF_THR     = LVL_W'(1 << (log_depth - 1));

    bufctrl_state_t   state;
    logic [CNT_W-1:0] counter;

    logic [1:0] phase_next;
    logic       phase_last;
    logic       fill_ok;
    logic       level_half;
    logic       run_fault;

    always_comb begin
        phase_last = (word_phase == PHASE_LAST);
        phase_next = phase_last ? '0 : word_phase + 2'd1;
        fill_ok    = (fifo_level >= FILL_THR);
        level_half = (fifo_level >= HALF_THR);
        // rd_en is the registered strobe actually seen by the buffer, so an
        // underflow is a strobe landing on an empty buffer in this cycle.
        run_fault  = (rd_en && fifo_empty) || fifo_full;
    end

    always_ff @(posedge usrclk) begin
        if (reset) begin
            state       <= ST_RST;
            fifo_rst    <= 1'b1;
            rd_en       <= 1'b0;
            word_phase  <= '0;
            txbufstatus <= '0;
            txresetdone <= 1'b0;
            counter     <= '0;
        end else begin
            // rd_en is a single-cycle pulse unless re-armed below.
            rd_en <= 1'b0;
            if (!txuserrdy) begin
                // Sticky error bit survives until the next flush.
                state                         <= ST_RST;
                fifo_rst                      <= 1'b1;
                word_phase                    <= '0;
                counter                       <= '0;
                txbufstatus[TXBUFSTATUS_HALF] <= 1'b0;
                txresetdone                   <= 1'b0;
            end else begin
                case (state)
                    ST_RST: begin
                        state       <= ST_FLUSH;
                        fifo_rst    <= 1'b1;
                        word_phase  <= '0;
                        counter     <= '0;
                        txbufstatus <= '0;
                        txresetdone <= 1'b0;
                    end
                    ST_FLUSH: begin
                        if (counter == FLUSH_LAST) begin
                            state    <= ST_FILL;
                            fifo_rst <= 1'b0;
                            counter  <= '0;
                        end else begin
                            counter <= counter + 1'b1;
                        end
                    end
                    ST_FILL, ST_RUN, ST_ERR: begin
                        word_phase                    <= phase_next;
                        txbufstatus[TXBUFSTATUS_HALF] <= level_half;
                        // A flush request outranks fault detection in the same cycle.
                        if (txbufreset_req || (state == ST_ERR && auto_recover != 0)) begin
                            state       <= ST_FLUSH;
                            fifo_rst    <= 1'b1;
                            word_phase  <= '0;
                            counter     <= '0;
                            txbufstatus <= '0;
                            txresetdone <= 1'b0;
                        end else if (state == ST_FILL) begin
                            if (fill_ok && phase_last) begin
                                state       <= ST_RUN;
                                rd_en       <= 1'b1;
                                txresetdone <= 1'b1;
                                counter     <= '0;
                            end else if (counter == TIMEOUT_LAST) begin
                                state                        <= ST_ERR;
                                txbufstatus[TXBUFSTATUS_ERR] <= 1'b1;
                                counter                      <= '0;
                            end else begin
                                counter <= counter + 1'b1;
                            end
                        end else if (state == ST_RUN) begin
                            if (run_fault) begin
                                state                        <= ST_ERR;
                                txbufstatus[TXBUFSTATUS_ERR] <= 1'b1;
                                txresetdone                  <= 1'b0;
                            end else begin
                                rd_en <= phase_last;
                            end
                        end
                    end
                    default: begin
                        state       <= ST_RST;
                        fifo_rst    <= 1'b1;
                        word_phase  <= '0;
                        counter     <= '0;
                        txbufstatus <= '0;
                        txresetdone <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gtxe2_chnl_tx_bufctrl.sv
// Bench for gtxe2_chnl_tx_bufctrl: four instances (div=2 auto, div=2 manual,
// div=1, div=4) share one input stream and are compared every cycle with a
// behavioural model built on elapsed-cycle counts.
module tb_gtxe2_chnl_tx_bufctrl;

    localparam int unsigned N         = 4;
    localparam int unsigned DIVS  [N] = '{2, 2, 1, 4};
    localparam int unsigned AUTOS [N] = '{1, 0, 1, 1};
    localparam int unsigned FLUSH_CYC = 8;
    localparam int unsigned FILL_LVL  = 4;
    localparam int unsigned TIMEOUT   = 64;
    localparam int unsigned HALF      = 4;

    logic usrclk = 1'b0;
    always #5 usrclk = ~usrclk;

    logic       reset, txuserrdy, txbufreset_req, fifo_empty, fifo_full;
    logic [3:0] fifo_level;

    logic [N-1:0]      fifo_rst_v, rd_en_v, done_v;
    logic [N-1:0][1:0] phase_v, status_v;

    gtxe2_chnl_tx_bufctrl #(.div(2), .log_depth(3), .flush_cycles(8), .fill_level(4),
                            .fill_timeout(64), .auto_recover(1)) u_div2_auto (
        .usrclk(usrclk), .reset(reset), .txuserrdy(txuserrdy), .txbufreset_req(txbufreset_req),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_level(fifo_level),
        .fifo_rst(fifo_rst_v[0]), .rd_en(rd_en_v[0]), .word_phase(phase_v[0]),
        .txbufstatus(status_v[0]), .txresetdone(done_v[0]));

    gtxe2_chnl_tx_bufctrl #(.div(2), .log_depth(3), .flush_cycles(8), .fill_level(4),
                            .fill_timeout(64), .auto_recover(0)) u_div2_manual (
        .usrclk(usrclk), .reset(reset), .txuserrdy(txuserrdy), .txbufreset_req(txbufreset_req),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_level(fifo_level),
        .fifo_rst(fifo_rst_v[1]), .rd_en(rd_en_v[1]), .word_phase(phase_v[1]),
        .txbufstatus(status_v[1]), .txresetdone(done_v[1]));

    gtxe2_chnl_tx_bufctrl #(.div(1), .log_depth(3), .flush_cycles(8), .fill_level(4),
                            .fill_timeout(64), .auto_recover(1)) u_div1 (
        .usrclk(usrclk), .reset(reset), .txuserrdy(txuserrdy), .txbufreset_req(txbufreset_req),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_level(fifo_level),
        .fifo_rst(fifo_rst_v[2]), .rd_en(rd_en_v[2]), .word_phase(phase_v[2]),
        .txbufstatus(status_v[2]), .txresetdone(done_v[2]));

    gtxe2_chnl_tx_bufctrl #(.div(4), .log_depth(3), .flush_cycles(8), .fill_level(4),
                            .fill_timeout(64), .auto_recover(1)) u_div4 (
        .usrclk(usrclk), .reset(reset), .txuserrdy(txuserrdy), .txbufreset_req(txbufreset_req),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_level(fifo_level),
        .fifo_rst(fifo_rst_v[3]), .rd_en(rd_en_v[3]), .word_phase(phase_v[3]),
        .txbufstatus(status_v[3]), .txresetdone(done_v[3]));

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_FLUSHING, M_FILLING, M_RUNNING, M_FAULTED} mode_t;

    mode_t       m_mode [N];
    int unsigned m_t    [N];   // cycles spent in the current FLUSHING/FILLING mode
    int unsigned m_tph  [N];   // cycles elapsed since the buffer left flush
    bit          m_err  [N];
    bit          m_lvl  [N];
    bit          m_rd   [N];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_flush(input int unsigned i);
        m_mode[i] = M_FLUSHING;
        m_t[i]    = 0;
        m_tph[i]  = 0;
        m_err[i]  = 1'b0;
        m_lvl[i]  = 1'b0;
    endtask

    task automatic model_step(input int unsigned i);
        int unsigned ph;
        bit          prev_rd;
        prev_rd = m_rd[i];
        m_rd[i] = 1'b0;
        if (reset) begin
            m_mode[i] = M_IDLE; m_t[i] = 0; m_tph[i] = 0; m_err[i] = 1'b0; m_lvl[i] = 1'b0;
        end else if (!txuserrdy) begin
            m_mode[i] = M_IDLE; m_t[i] = 0; m_tph[i] = 0; m_lvl[i] = 1'b0;
        end else if (m_mode[i] == M_IDLE) begin
            start_flush(i);
        end else if (m_mode[i] == M_FLUSHING) begin
            if (m_t[i] == FLUSH_CYC - 1) begin
                m_mode[i] = M_FILLING; m_t[i] = 0; m_tph[i] = 0;
            end else begin
                m_t[i]++;
            end
        end else begin
            ph = m_tph[i] % DIVS[i];
            m_tph[i]++;
            m_lvl[i] = (fifo_level >= HALF);
            if (txbufreset_req) begin
                start_flush(i);
            end else if (m_mode[i] == M_FILLING) begin
                if (fifo_level >= FILL_LVL && ph == DIVS[i] - 1) begin
                    m_mode[i] = M_RUNNING; m_rd[i] = 1'b1;
                end else if (m_t[i] == TIMEOUT - 1) begin
                    m_mode[i] = M_FAULTED; m_err[i] = 1'b1;
                end else begin
                    m_t[i]++;
                end
            end else if (m_mode[i] == M_RUNNING) begin
                if ((prev_rd && fifo_empty) || fifo_full) begin
                    m_mode[i] = M_FAULTED; m_err[i] = 1'b1;
                end else begin
                    m_rd[i] = (ph == DIVS[i] - 1);
                end
            end else if (AUTOS[i] != 0) begin
                start_flush(i);
            end
        end
    endtask

    task automatic check_inst(input int unsigned i);
        bit active;
        active = (m_mode[i] == M_FILLING) || (m_mode[i] == M_RUNNING) || (m_mode[i] == M_FAULTED);
        check_eq($sformatf("fifo_rst[%0d]", i), fifo_rst_v[i], !active);
        check_eq($sformatf("rd_en[%0d]", i), rd_en_v[i], m_rd[i]);
        check_eq($sformatf("word_phase[%0d]", i), phase_v[i], active ? m_tph[i] % DIVS[i] : 0);
        check_eq($sformatf("txbufstatus[%0d]", i), status_v[i], {m_err[i], m_lvl[i]});
        check_eq($sformatf("txresetdone[%0d]", i), done_v[i], m_mode[i] == M_RUNNING);
    endtask

    task automatic tick();
        @(posedge usrclk);
        for (int unsigned i = 0; i < N; i++) model_step(i);
        @(negedge usrclk);
        for (int unsigned i = 0; i < N; i++) check_inst(i);
    endtask

    task automatic wait_rd0();
        for (int k = 0; k < 10 && !rd_en_v[0]; k++) tick();
        check_eq("wait_rd_en0", rd_en_v[0], 1);
    endtask

    int unsigned cnt, cnt1, cnt4;
    bit          done_seen;

    initial begin
        reset = 1'b1; txuserrdy = 1'b1; txbufreset_req = 1'b0;
        fifo_empty = 1'b0; fifo_full = 1'b0; fifo_level = '0;
        repeat (3) tick();
        check_eq("rst_fifo_rst", fifo_rst_v[0], 1);
        check_eq("rst_rd_en", rd_en_v[0], 0);
        check_eq("rst_phase", phase_v[0], 0);
        check_eq("rst_status", status_v[0], 0);
        check_eq("rst_done", done_v[0], 0);

        // Bring-up: level rises to 4 at cycle 12
        reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 12) fifo_level = 4'd4;
            tick();
            if (fifo_rst_v[0]) cnt++;
        end
        check_eq("flush_len", cnt, FLUSH_CYC);
        check_eq("all_running", done_v, 4'hF);
        cnt = 0; cnt1 = 0; cnt4 = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            cnt  += rd_en_v[0];
            cnt1 += rd_en_v[2];
            cnt4 += rd_en_v[3];
        end
        check_eq("rd_rate_div2", cnt, 6);
        check_eq("rd_rate_div1", cnt1, 12);
        check_eq("rd_rate_div4", cnt4, 3);

        // Underflow on a strobe cycle, auto recovery
        wait_rd0();
        fifo_empty = 1'b1;
        tick();
        fifo_empty = 1'b0;
        check_eq("uf_err_bit", status_v[0][1], 1);
        check_eq("uf_in_err", fifo_rst_v[0], 0);
        check_eq("uf_rd_drop", rd_en_v[0], 0);
        tick();
        check_eq("uf_recover_flush", fifo_rst_v[0], 1);
        check_eq("uf_recover_clear", status_v[0][1], 0);

        // Overflow with manual recovery (instance 1)
        txbufreset_req = 1'b1; tick(); txbufreset_req = 1'b0;
        repeat (40) tick();
        check_eq("run_before_full", done_v, 4'hF);
        fifo_full = 1'b1; tick(); fifo_full = 1'b0;
        repeat (50) tick();
        check_eq("of_held_err", status_v[1][1], 1);
        check_eq("of_held_done", done_v[1], 0);
        check_eq("of_held_nofl", fifo_rst_v[1], 0);
        txbufreset_req = 1'b1; tick(); txbufreset_req = 1'b0;
        check_eq("of_req_flush", fifo_rst_v[1], 1);
        check_eq("of_req_clear", status_v[1][1], 0);

        // Fill timeout with level stuck at 2
        fifo_level = 4'd2;
        reset = 1'b1; tick(); reset = 1'b0;
        cnt = 0; done_seen = 1'b0;
        for (int k = 0; k < 200 && !status_v[1][1]; k++) begin
            tick();
            if (!status_v[1][1] && !fifo_rst_v[1]) cnt++;
            if (done_v[1]) done_seen = 1'b1;
        end
        check_eq("timeout_err", status_v[1][1], 1);
        check_eq("timeout_len", cnt, TIMEOUT);
        check_eq("timeout_no_done", done_seen, 0);

        // Flush request and underflow in the same cycle, then txuserrdy drop in FLUSH
        fifo_level = 4'd4;
        txbufreset_req = 1'b1; tick(); txbufreset_req = 1'b0;
        repeat (30) tick();
        wait_rd0();
        fifo_empty = 1'b1; txbufreset_req = 1'b1;
        tick();
        fifo_empty = 1'b0; txbufreset_req = 1'b0;
        check_eq("req_vs_uf_flush", fifo_rst_v[0], 1);
        check_eq("req_vs_uf_clear", status_v[0][1], 0);
        tick();
        txuserrdy = 1'b0; tick(); txuserrdy = 1'b1;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (!fifo_rst_v[0]) break;
            cnt++;
        end
        check_eq("rdy_drop_restart", cnt, FLUSH_CYC);

        // Half-full flag follows level one cycle later
        repeat (20) tick();
        fifo_level = 4'd3; tick(); tick();
        check_eq("half_lvl3", status_v[0][0], 0);
        fifo_level = 4'd4; tick();
        check_eq("half_lvl4", status_v[0][0], 1);
        fifo_level = 4'd3; tick();
        check_eq("half_lvl3b", status_v[0][0], 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            fifo_level     = 4'($urandom_range(0, 8));
            fifo_empty     = ($urandom % 16) == 0;
            fifo_full      = ($urandom % 32) == 0;
            txbufreset_req = ($urandom % 40) == 0;
            txuserrdy      = ($urandom % 100) != 0;
            reset          = ($urandom % 300) == 0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
